timer_ctrl: RTL and testbench

Register-programmed down-counting timer controller. It sequences a prescaled counter through idle, running and expired phases and supports one-shot and periodic modes. It raises a maskable interrupt on expiry. It sits behind the peripheral register bus and gives software a single timer channel.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_prescaler.sv | 31 +++
 rtl/timer_ctrl.sv | 139 +++++++++++++
 tb/tb_timer_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: register map, CTRL bit layout
// and state encoding.
`default_nettype none

package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_VALUE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQEN    = 2;
  localparam int CTRL_PS_LSB   = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every prescale+1 cycles while run is high.
`default_nettype none

module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  // >= rather than == so a live shrink of prescale below cnt still ticks
  assign tick = run && (cnt >= prescale);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt >= prescale) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// Register-programmed down-counting timer with one-shot/periodic modes and a
// maskable expiry interrupt.
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  output logic             irq,
  output logic             running
);

  state_t                    state, state_n;
  logic                      en, en_n;
  logic                      periodic, periodic_n;
  logic                      irq_en, irq_en_n;
  logic [PRESCALE_WIDTH-1:0] prescale, prescale_n;
  logic [WIDTH-1:0]          reload, reload_n;
  logic [WIDTH-1:0]          value, value_n;
  logic                      expired, expired_n;
  logic                      start;
  logic                      tick;

  wire ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  wire reload_wr = cfg_we && (cfg_addr == ADDR_RELOAD);
  wire status_wr = cfg_we && (cfg_addr == ADDR_STATUS);

  timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .run      (state == RUNNING),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      reload   <= '0;
      value    <= '0;
      expired  <= 1'b0;
    end else begin
      state    <= state_n;
      en       <= en_n;
      periodic <= periodic_n;
      irq_en   <= irq_en_n;
      prescale <= prescale_n;
      reload   <= reload_n;
      value    <= value_n;
      expired  <= expired_n;
    end
  end

  // Ordering below encodes priorities: clear before expiry set, CTRL write last.
  always_comb begin
    state_n    = state;
    en_n       = en;
    periodic_n = periodic;
    irq_en_n   = irq_en;
    prescale_n = prescale;
    reload_n   = reload;
    value_n    = value;
    expired_n  = expired;
    start      = 1'b0;

    if (status_wr && cfg_wdata[0]) expired_n = 1'b0;

    if ((state == RUNNING) && tick) begin
      if (value != '0) begin
        value_n = value - 1'b1;
      end else begin
        expired_n = 1'b1;
        if (periodic) begin
          value_n = reload;
        end else begin
          state_n = IDLE;
          en_n    = 1'b0;
        end
      end
    end

    if (reload_wr) reload_n = cfg_wdata;

    if (ctrl_wr) begin
      periodic_n = cfg_wdata[CTRL_PERIODIC];
      irq_en_n   = cfg_wdata[CTRL_IRQEN];
      prescale_n = cfg_wdata[CTRL_PS_LSB +: PRESCALE_WIDTH];
      if (cfg_wdata[CTRL_EN]) begin
        if (state == IDLE) begin
          state_n = RUNNING;
          en_n    = 1'b1;
          value_n = reload;
          start   = 1'b1;
        end
      end else begin
        state_n = IDLE;
        en_n    = 1'b0;
        value_n = value;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL: begin
        cfg_rdata[CTRL_EN]                         = en;
        cfg_rdata[CTRL_PERIODIC]                   = periodic;
        cfg_rdata[CTRL_IRQEN]                      = irq_en;
        cfg_rdata[CTRL_PS_LSB +: PRESCALE_WIDTH]   = prescale;
      end
      ADDR_RELOAD: cfg_rdata = reload;
      ADDR_VALUE:  cfg_rdata = value;
      default: begin
        cfg_rdata[0] = expired;
        cfg_rdata[1] = (state == RUNNING);
      end
    endcase
  end

  assign irq     = expired && irq_en;
  assign running = (state == RUNNING);

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_timer_ctrl;

  localparam int WIDTH = 32;
  localparam int PW    = 8;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_VALUE  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_addr = 2'd0;
  logic [WIDTH-1:0] cfg_wdata = '0;
  logic [WIDTH-1:0] cfg_rdata;
  logic             irq;
  logic             running;

  int n_cmp = 0;
  int n_bad = 0;

  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq       (irq),
    .running   (running)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    expect_reg("rst_ctrl",   A_CTRL,   32'h0);
    expect_reg("rst_reload", A_RELOAD, 32'h0);
    expect_reg("rst_value",  A_VALUE,  32'h0);
    expect_reg("rst_status", A_STATUS, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_running", {31'b0, running}, 32'h0);

    // One-shot, R=3, P=0: expiry at edge 4
    wr(A_RELOAD, 32'd3);
    wr(A_VALUE, 32'hDEAD);
    expect_reg("value_ro", A_VALUE, 32'h0);
    wr(A_CTRL, 32'h1);
    expect_reg("os_v3", A_VALUE, 32'd3);
    check("os_running", {31'b0, running}, 32'h1);
    step(1); expect_reg("os_v2", A_VALUE, 32'd2);
    step(1); expect_reg("os_v1", A_VALUE, 32'd1);
    step(1); expect_reg("os_v0", A_VALUE, 32'd0);
    expect_reg("os_notexp", A_STATUS, 32'h2);
    step(1);
    expect_reg("os_status", A_STATUS, 32'h1);
    expect_reg("os_ctrl",   A_CTRL,   32'h0);
    expect_reg("os_vhold",  A_VALUE,  32'd0);
    check("os_irq", {31'b0, irq}, 32'h0);
    check("os_running_lo", {31'b0, running}, 32'h0);
    wr(A_STATUS, 32'h1);
    expect_reg("os_w1c", A_STATUS, 32'h0);

    // Periodic with irq, R=2, P=2: expiry every 9 edges
    wr(A_RELOAD, 32'd2);
    wr(A_CTRL, 32'h0207);
    expect_reg("per_ctrl", A_CTRL, 32'h0207);
    step(8);
    expect_reg("per_e8", A_STATUS, 32'h2);
    step(1);
    expect_reg("per_e9", A_STATUS, 32'h3);
    expect_reg("per_reload", A_VALUE, 32'd2);
    check("per_irq", {31'b0, irq}, 32'h1);
    wr(A_STATUS, 32'h1);                               // edge 10
    check("per_irq_clr", {31'b0, irq}, 32'h0);
    step(7);
    expect_reg("per_e17", A_STATUS, 32'h2);
    step(1);
    expect_reg("per_e18", A_STATUS, 32'h3);
    check("per_irq2", {31'b0, irq}, 32'h1);

    // Clear at edge 19, then W1C collides with expiry at edge 27
    wr(A_STATUS, 32'h1);
    step(7);
    expect_reg("col_e26", A_STATUS, 32'h2);
    wr(A_STATUS, 32'h1);
    expect_reg("col_e27", A_STATUS, 32'h3);
    check("col_irq", {31'b0, irq}, 32'h1);

    // Live reprogramming: RELOAD and CTRL writes must not restart the period
    wr(A_RELOAD, 32'd5);                               // edge 28
    expect_reg("live_v_e28", A_VALUE, 32'd2);
    wr(A_CTRL, 32'h0207);                              // edge 29
    expect_reg("live_v_e29", A_VALUE, 32'd2);
    step(1);
    expect_reg("live_v_e30", A_VALUE, 32'd1);
    step(3);
    expect_reg("live_v_e33", A_VALUE, 32'd0);
    step(3);
    expect_reg("live_v_e36", A_VALUE, 32'd5);

    // Disable / resume
    wr(A_CTRL, 32'h0);
    check("dis_running0", {31'b0, running}, 32'h0);
    wr(A_RELOAD, 32'd9);
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h1);
    expect_reg("dr_v9", A_VALUE, 32'd9);
    step(2);
    expect_reg("dr_v7", A_VALUE, 32'd7);
    wr(A_CTRL, 32'h0);
    expect_reg("dr_hold", A_VALUE, 32'd7);
    check("dr_running", {31'b0, running}, 32'h0);
    step(2);
    expect_reg("dr_hold2", A_VALUE, 32'd7);
    wr(A_CTRL, 32'h1);
    expect_reg("dr_resume", A_VALUE, 32'd9);
    check("dr_running1", {31'b0, running}, 32'h1);

    // Reset mid-run with irq high and VALUE=4
    wr(A_CTRL, 32'h0);
    wr(A_RELOAD, 32'd4);
    wr(A_CTRL, 32'h7);
    step(5);
    expect_reg("mr_v4", A_VALUE, 32'd4);
    check("mr_irq", {31'b0, irq}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_reg("mr_ctrl",   A_CTRL,   32'h0);
    expect_reg("mr_reload", A_RELOAD, 32'h0);
    expect_reg("mr_value",  A_VALUE,  32'h0);
    expect_reg("mr_status", A_STATUS, 32'h0);
    check("mr_irq0", {31'b0, irq}, 32'h0);
    check("mr_running0", {31'b0, running}, 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
